// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the EX-stage forwarding/hazard control:
//   - operand-mux select encodings (register file, EX/MEM, MEM/WB)
//   - register-address width
//   - pipeline tracker record and its bubble value
//   - tracker hit helper used by the forwarding comparators
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] SEL_REG   = 2'b00;
    localparam logic [1:0] SEL_EXMEM = 2'b01;
    localparam logic [1:0] SEL_MEMWB = 2'b10;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dest;
        logic              regwrite;
        logic              memread;
    } trk_t;

    localparam trk_t TRK_BUBBLE = '{
        valid:    1'b0,
        dest:     {REG_AW{1'b0}},
        regwrite: 1'b0,
        memread:  1'b0
    };

    // A tracked instruction can feed source s only if it really writes s;
    // r0 is hard-wired so it is never a forwarding target.
    function automatic logic trk_hit(input trk_t t, input logic [REG_AW-1:0] s);
        return (s != {REG_AW{1'b0}}) && t.valid && t.regwrite && (t.dest == s);
    endfunction

endpackage

// File: rtl/fwd_ctrl_unit_fwd_match.sv
// ---------------------------------------------------------------------------
// fwd_match
// Pure-combinational forwarding comparator for one EX source operand.
// Ports:
//   src     - source register of the instruction in ID
//   ex_trk  - tracker of the instruction currently in EX
//   mem_trk - tracker of the instruction currently in MEM
//   sel     - mux select the operand will need once it reaches EX
// ---------------------------------------------------------------------------
module fwd_match
    import pipe_pkg::*;
(
    input  logic [REG_AW-1:0] src,
    input  trk_t              ex_trk,
    input  trk_t              mem_trk,
    output logic [1:0]        sel
);

    // Youngest producer wins: the EX instruction will sit in EX/MEM when the
    // consumer executes, the MEM instruction will sit in MEM/WB.
    always_comb begin
        sel = SEL_REG;
        if (trk_hit(ex_trk, src)) begin
            sel = SEL_EXMEM;
        end else if (trk_hit(mem_trk, src)) begin
            sel = SEL_MEMWB;
        end else begin
            sel = SEL_REG;
        end
    end

endmodule

// File: rtl/fwd_ctrl_unit.sv
// ---------------------------------------------------------------------------
// fwd_ctrl_unit
// Forwarding and load-use hazard control for the EX stage of the 5-stage
// pipeline. Tracks {valid, dest, regwrite, memread} for EX, MEM and WB,
// produces registered operand-mux selects aligned with the EX instruction,
// inserts one bubble on a load-use hazard and counts stalls (saturating).
// Ports:
//   clk, rst_n        - clock (rising edge), async active-low reset
//   id_*              - decoded fields of the instruction in ID
//   flush             - squash the instruction entering EX
//   sel_a, sel_b      - operand A/B mux selects (00 RF, 01 EX/MEM, 10 MEM/WB)
//   stall             - hold PC and IF/ID; a bubble enters EX this cycle
//   ex_dest           - destination of the instruction now in EX
//   ex_regwrite       - EX instruction writes a register (0 for a bubble)
//   stall_count       - load-use stalls since reset, saturating at all-ones
// ---------------------------------------------------------------------------
module fwd_ctrl_unit
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              flush,
    output logic [1:0]        sel_a,
    output logic [1:0]        sel_b,
    output logic              stall,
    output logic [REG_AW-1:0] ex_dest,
    output logic              ex_regwrite,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    trk_t             ex_r;
    trk_t             mem_r;
    trk_t             wb_r;
    logic [1:0]       sel_a_r;
    logic [1:0]       sel_b_r;
    logic [CNT_W-1:0] cnt_r;

    trk_t             id_trk_s;
    trk_t             ex_nxt_s;
    logic             bubble_s;
    logic             stall_s;
    logic [1:0]       match_a_s;
    logic [1:0]       match_b_s;
    logic [1:0]       sel_a_nxt_s;
    logic [1:0]       sel_b_nxt_s;

    fwd_match u_match_a (
        .src     (id_rs),
        .ex_trk  (ex_r),
        .mem_trk (mem_r),
        .sel     (match_a_s)
    );

    fwd_match u_match_b (
        .src     (id_rt),
        .ex_trk  (ex_r),
        .mem_trk (mem_r),
        .sel     (match_b_s)
    );

    // Load-use hazard: the load in EX produces its data too late for the ID
    // consumer. Only tracker state and ID inputs feed this (never flush).
    always_comb begin
        stall_s = id_valid && ex_r.valid && ex_r.memread &&
                  (ex_r.dest != {REG_AW{1'b0}}) &&
                  ((ex_r.dest == id_rs) || (ex_r.dest == id_rt));
    end

    // Next EX contents and selects; a bubble always carries 00 selects.
    always_comb begin
        id_trk_s    = '{valid: 1'b1, dest: id_dest,
                        regwrite: id_regwrite, memread: id_memread};
        bubble_s    = flush || stall_s || !id_valid;
        ex_nxt_s    = TRK_BUBBLE;
        sel_a_nxt_s = SEL_REG;
        sel_b_nxt_s = SEL_REG;
        if (bubble_s) begin
            ex_nxt_s    = TRK_BUBBLE;
            sel_a_nxt_s = SEL_REG;
            sel_b_nxt_s = SEL_REG;
        end else begin
            ex_nxt_s    = id_trk_s;
            sel_a_nxt_s = match_a_s;
            sel_b_nxt_s = match_b_s;
        end
    end

    // Tracker pipeline, registered selects and saturating stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_r    <= TRK_BUBBLE;
            mem_r   <= TRK_BUBBLE;
            wb_r    <= TRK_BUBBLE;
            sel_a_r <= SEL_REG;
            sel_b_r <= SEL_REG;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            ex_r    <= ex_nxt_s;
            mem_r   <= ex_r;
            wb_r    <= mem_r;
            sel_a_r <= sel_a_nxt_s;
            sel_b_r <= sel_b_nxt_s;
            if (stall_s && (cnt_r != CNT_MAX)) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign sel_a       = sel_a_r;
    assign sel_b       = sel_b_r;
    assign stall       = stall_s;
    assign ex_dest     = ex_r.dest;
    assign ex_regwrite = ex_r.regwrite;
    assign stall_count = cnt_r;

endmodule

// File: tb/tb_fwd_ctrl_unit.sv
// Directed-vector bench for fwd_ctrl_unit (stall counter narrowed to 4 bits
// so saturation is reachable quickly).
module tb_fwd_ctrl_unit;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       id_dest;
    logic             id_regwrite;
    logic             id_memread;
    logic             flush;
    logic [1:0]       sel_a;
    logic [1:0]       sel_b;
    logic             stall;
    logic [4:0]       ex_dest;
    logic             ex_regwrite;
    logic [CNT_W-1:0] stall_count;

    int n_vec;
    int n_bad;

    fwd_ctrl_unit #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_dest     (id_dest),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .flush       (flush),
        .sel_a       (sel_a),
        .sel_b       (sel_b),
        .stall       (stall),
        .ex_dest     (ex_dest),
        .ex_regwrite (ex_regwrite),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] d, input logic rw, input logic mr);
        id_valid    = v;
        id_rs       = rs;
        id_rt       = rt;
        id_dest     = d;
        id_regwrite = rw;
        id_memread  = mr;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        flush = 1'b0;
        rst_n = 1'b0;
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

        // 1. reset with random ID activity
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'($urandom));
            flush = 1'($urandom);
            tick;
        end
        check_eq("rst_stall_held", {31'd0, stall}, 32'd0);
        flush = 1'b0;
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_sel_a", {30'd0, sel_a}, 32'd0);
        check_eq("rst_sel_b", {30'd0, sel_b}, 32'd0);
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        check_eq("rst_count", {28'd0, stall_count}, 32'd0);
        check_eq("rst_ex_rw", {31'd0, ex_regwrite}, 32'd0);

        // 2. EX/MEM forward: add r5 then sub r6 <- r5, r3
        tick;
        issue(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        check_eq("exmem_stall0", {31'd0, stall}, 32'd0);
        tick;
        issue(1'b1, 5'd5, 5'd3, 5'd6, 1'b1, 1'b0);
        check_eq("exmem_stall1", {31'd0, stall}, 32'd0);
        tick;
        check_eq("exmem_sel_a", {30'd0, sel_a}, 32'd1);
        check_eq("exmem_sel_b", {30'd0, sel_b}, 32'd0);
        check_eq("exmem_ex_dest", {27'd0, ex_dest}, 32'd6);

        // 3a. MEM/WB forward: r7, unrelated r8, consumer rs=7
        issue(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
        tick;
        issue(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0);
        tick;
        issue(1'b1, 5'd7, 5'd9, 5'd10, 1'b1, 1'b0);
        tick;
        check_eq("memwb_sel_a", {30'd0, sel_a}, 32'd2);
        check_eq("memwb_sel_b", {30'd0, sel_b}, 32'd0);

        // 3b. priority: r7, r7, consumer rs=rt=7 -> youngest (EX/MEM)
        issue(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
        tick;
        issue(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
        tick;
        issue(1'b1, 5'd7, 5'd7, 5'd12, 1'b1, 1'b0);
        tick;
        check_eq("prio_sel_a", {30'd0, sel_a}, 32'd1);
        check_eq("prio_sel_b", {30'd0, sel_b}, 32'd1);

        // 4. load-use: lw r4 then consumer rt=4
        issue(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1);
        check_eq("lu_no_stall_ld", {31'd0, stall}, 32'd0);
        tick;
        issue(1'b1, 5'd3, 5'd4, 5'd11, 1'b1, 1'b0);
        check_eq("lu_stall", {31'd0, stall}, 32'd1);
        tick;
        check_eq("lu_bubble_rw", {31'd0, ex_regwrite}, 32'd0);
        check_eq("lu_bubble_sel_b", {30'd0, sel_b}, 32'd0);
        check_eq("lu_count1", {28'd0, stall_count}, 32'd1);
        check_eq("lu_stall_once", {31'd0, stall}, 32'd0);
        tick;
        check_eq("lu_sel_b", {30'd0, sel_b}, 32'd2);
        check_eq("lu_sel_a", {30'd0, sel_a}, 32'd0);
        check_eq("lu_count_hold", {28'd0, stall_count}, 32'd1);
        check_eq("lu_ex_rw", {31'd0, ex_regwrite}, 32'd1);
        check_eq("lu_ex_dest", {27'd0, ex_dest}, 32'd11);

        // 5a. r0 never forwarded
        issue(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
        tick;
        issue(1'b1, 5'd0, 5'd0, 5'd13, 1'b1, 1'b0);
        tick;
        check_eq("r0_sel_a", {30'd0, sel_a}, 32'd0);
        check_eq("r0_sel_b", {30'd0, sel_b}, 32'd0);

        // 5b. flush together with a load-use stall
        issue(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1);
        tick;
        issue(1'b1, 5'd4, 5'd3, 5'd14, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        check_eq("fl_stall", {31'd0, stall}, 32'd1);
        tick;
        flush = 1'b0;
        check_eq("fl_bubble_rw", {31'd0, ex_regwrite}, 32'd0);
        check_eq("fl_count2", {28'd0, stall_count}, 32'd2);
        check_eq("fl_sel_a", {30'd0, sel_a}, 32'd0);
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick;

        // 6. saturation: 20 more load-use stalls on a 4-bit counter
        for (int k = 0; k < 20; k++) begin
            issue(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1);
            tick;
            issue(1'b1, 5'd9, 5'd4, 5'd15, 1'b1, 1'b0);
            check_eq("sat_stall", {31'd0, stall}, 32'd1);
            tick;
        end
        check_eq("sat_count", {28'd0, stall_count}, 32'hF);
        issue(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1);
        tick;
        issue(1'b1, 5'd9, 5'd4, 5'd15, 1'b1, 1'b0);
        tick;
        check_eq("sat_hold", {28'd0, stall_count}, 32'hF);

        // reset in the middle of a stall clears everything at once
        issue(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1);
        tick;
        issue(1'b1, 5'd9, 5'd4, 5'd15, 1'b1, 1'b0);
        check_eq("mid_stall_pre", {31'd0, stall}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_stall", {31'd0, stall}, 32'd0);
        check_eq("mid_rst_count", {28'd0, stall_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        check_eq("mid_rel_rw", {31'd0, ex_regwrite}, 32'd1);
        check_eq("mid_rel_dest", {27'd0, ex_dest}, 32'd15);
        check_eq("mid_rel_count", {28'd0, stall_count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
